// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with an AXI-Stream-like output.
// Frames are 1 start bit, DATA_WIDTH data bits (LSB first) and 1 stop bit.
// Each bit lasts prescale*8 clock cycles, and prescale 0 is treated as 1.
// Bits are sampled at mid-bit, after a 2-flop synchronizer on rxd.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   prescale       bit period = prescale*8 cycles, latched at start detection
//   rxd            asynchronous serial input, idle high
//   m_axis_tdata   last received word
//   m_axis_tvalid  m_axis_tdata holds an unconsumed word
//   m_axis_tready  downstream accepts the word
//   busy           a frame is being received
//   overrun_error  1-cycle pulse when an unconsumed word is overwritten
//   frame_error    1-cycle pulse when the stop bit samples low
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           prescale,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  rxd_meta;
    logic                  rxs;
    logic [18:0]           period;
    logic [18:0]           cnt;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  armed;

    logic [15:0]           prescale_eff;
    logic [18:0]           period_new;
    logic                  cnt_zero;
    logic                  start_det;
    logic                  last_bit;
    logic                  stop_sample;

    assign prescale_eff = (prescale == '0) ? 16'd1 : prescale;
    assign period_new   = {prescale_eff, 3'b000};
    assign cnt_zero     = (cnt == '0);
    // A start is only accepted once the line has been seen high while idle.
    // This stops a line held low after a framing error from retriggering.
    assign start_det    = (state == IDLE) && armed && !rxs;
    assign last_bit     = (bit_cnt == 4'(DATA_WIDTH - 1));
    assign stop_sample  = (state == STOP) && cnt_zero;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_det) state_next = START;
            START: if (cnt_zero) state_next = rxs ? IDLE : DATA;
            DATA:  if (cnt_zero && last_bit) state_next = STOP;
            STOP:  if (cnt_zero) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Synchronizer, timing counters, shift register and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta      <= 1'b1;
            rxs           <= 1'b1;
            period        <= '0;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            armed         <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            rxd_meta      <= rxd;
            rxs           <= rxd_meta;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;

            if (state != IDLE) begin
                armed <= 1'b0;
            end else if (rxs) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_det) begin
                        period  <= period_new;
                        // Half a bit period: the start-bit check lands mid-bit.
                        cnt     <= {1'b0, period_new[18:1]} - 19'd1;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (cnt_zero) begin
                        cnt <= period - 19'd1;
                    end else begin
                        cnt <= cnt - 19'd1;
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        shift_reg <= {rxs, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        cnt       <= period - 19'd1;
                    end else begin
                        cnt <= cnt - 19'd1;
                    end
                end
                STOP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 19'd1;
                    end
                end
                default: ;
            endcase

            // A commit takes priority over a handshake clearing tvalid.
            // If both fall in the same cycle, the old word is consumed and the
            // new word becomes valid, so no overrun is reported.
            if (stop_sample && rxs) begin
                m_axis_tdata  <= shift_reg;
                m_axis_tvalid <= 1'b1;
                overrun_error <= m_axis_tvalid && !m_axis_tready;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (stop_sample && !rxs) begin
                frame_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// It drives serial frames bit by bit. A passive monitor records what the
// receiver emits. Each test compares the record with the frame-level
// expectations.
module tb_uart_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  prescale;
    logic         rxd;
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         busy;
    logic         ovr;
    logic         fe;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_rx #(.DATA_WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .prescale      (prescale),
        .rxd           (rxd),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .busy          (busy),
        .overrun_error (ovr),
        .frame_error   (fe)
    );

    // Passive monitor, sampled on the falling edge.
    int           cyc = 0;
    int           busy_cnt, busy_rise, tvalid_hi, tvalid_rise_cyc, ovr_cnt, fe_cnt;
    logic         busy_q   = 1'b0;
    logic         tvalid_q = 1'b0;
    logic [W-1:0] got_q[$];

    always @(negedge clk) begin
        cyc++;
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && busy_q !== 1'b1) busy_rise++;
        busy_q = busy;
        if (tvalid === 1'b1) tvalid_hi++;
        if (tvalid === 1'b1 && tvalid_q !== 1'b1) tvalid_rise_cyc = cyc;
        tvalid_q = tvalid;
        if (ovr === 1'b1) ovr_cnt++;
        if (fe === 1'b1) fe_cnt++;
        if (tvalid === 1'b1 && tready === 1'b1) got_q.push_back(tdata);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        busy_cnt        = 0;
        busy_rise       = 0;
        tvalid_hi       = 0;
        tvalid_rise_cyc = 0;
        ovr_cnt         = 0;
        fe_cnt          = 0;
        got_q.delete();
    endtask

    function automatic int period_of(input int ps);
        return ((ps == 0) ? 1 : ps) * 8;
    endfunction

    // Busy spans half a bit for the start check, then W data bits and the stop bit.
    function automatic int busy_len(input int ps);
        return period_of(ps) / 2 + (W + 1) * period_of(ps);
    endfunction

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    // scramble >= 0 changes prescale shortly after the start edge.
    // The receiver has already latched the period by then, so the frame is unaffected.
    task automatic send_frame(input logic [W-1:0] d, input logic stop_bit,
                              input int ps, input int scramble);
        logic [W+1:0] frame;
        int p;
        frame    = {stop_bit, d, 1'b0};
        p        = period_of(ps);
        prescale = 16'(ps);
        for (int i = 0; i < W + 2; i++) begin
            rxd = frame[i];
            for (int c = 0; c < p; c++) begin
                if (i == 0 && c == 4 && scramble >= 0) prescale = 16'(scramble);
                tick();
            end
        end
        prescale = 16'(ps);
    endtask

    task automatic drain();
        tready = 1'b1;
        tick();
        tready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rxd = 1'b1; tready = 1'b0; prescale = 16'd1;
        repeat (3) tick();
        vectors++; if (tdata !== '0) begin miscompares++; $display("FAIL reset_tdata: got %h expected 00", tdata); end
        vectors++; if (tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (ovr !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", ovr); end
        vectors++; if (fe !== 1'b0) begin miscompares++; $display("FAIL reset_frame_error: got %b expected 0", fe); end
        rst_n = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        tready = 1'b1;
        clear_mon();
        send_frame(8'h55, 1'b1, 1, -1);
        idle(20);
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL basic_count: got %0d expected 1", got_q.size()); end
        else begin
            vectors++; if (got_q[0] !== 8'h55) begin miscompares++; $display("FAIL basic_tdata: got %h expected 55", got_q[0]); end
        end
        vectors++; if (tvalid_hi != 1) begin miscompares++; $display("FAIL basic_tvalid_cycles: got %0d expected 1", tvalid_hi); end
        vectors++; if (busy_cnt != busy_len(1)) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cnt, busy_len(1)); end
        vectors++; if (ovr_cnt != 0 || fe_cnt != 0) begin miscompares++; $display("FAIL basic_errors: got ovr=%0d fe=%0d expected 0/0", ovr_cnt, fe_cnt); end
    endtask

    task automatic test_overrun();
        tready = 1'b0;
        clear_mon();
        send_frame(8'hA3, 1'b1, 4, -1);
        idle(10);
        vectors++; if (tvalid !== 1'b1 || tdata !== 8'hA3) begin miscompares++; $display("FAIL overrun_first: got %b/%h expected 1/a3", tvalid, tdata); end
        send_frame(8'h3C, 1'b1, 4, -1);
        idle(10);
        vectors++; if (tvalid !== 1'b1 || tdata !== 8'h3C) begin miscompares++; $display("FAIL overrun_second: got %b/%h expected 1/3c", tvalid, tdata); end
        vectors++; if (ovr_cnt != 1) begin miscompares++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ovr_cnt); end
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL overrun_no_handshake: got %0d words expected 0", got_q.size()); end
        drain();
        vectors++; if (got_q.size() != 1 || tvalid !== 1'b0) begin miscompares++; $display("FAIL overrun_drain: got %0d words tvalid=%b expected 1/0", got_q.size(), tvalid); end
        else begin
            vectors++; if (got_q[0] !== 8'h3C) begin miscompares++; $display("FAIL overrun_drain_data: got %h expected 3c", got_q[0]); end
        end
    endtask

    task automatic test_commit_handshake();
        tready = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1, 1, -1);
        idle(10);
        // Two synchronizer stages plus the start detect, then the frame's sample points.
        // The commit edge falls 3 + busy_len cycles after the start edge is driven.
        fork
            send_frame(8'h22, 1'b1, 1, -1);
            begin
                repeat (3 + busy_len(1) - 1) tick();
                tready = 1'b1;
                tick();
                tready = 1'b0;
            end
        join
        idle(10);
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL commit_hs_count: got %0d expected 1", got_q.size()); end
        else begin
            vectors++; if (got_q[0] !== 8'h11) begin miscompares++; $display("FAIL commit_hs_old: got %h expected 11", got_q[0]); end
        end
        vectors++; if (tvalid !== 1'b1 || tdata !== 8'h22) begin miscompares++; $display("FAIL commit_hs_new: got %b/%h expected 1/22", tvalid, tdata); end
        vectors++; if (ovr_cnt != 0) begin miscompares++; $display("FAIL commit_hs_overrun: got %0d expected 0", ovr_cnt); end
        drain();
    endtask

    task automatic test_frame_error();
        tready = 1'b1;
        clear_mon();
        send_frame(8'hFF, 1'b0, 2, -1);
        repeat (3 * period_of(2)) tick();   // line stays low after the bad stop bit
        vectors++; if (fe_cnt != 1) begin miscompares++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt); end
        vectors++; if (tvalid_hi != 0) begin miscompares++; $display("FAIL ferr_tvalid: got %0d expected 0", tvalid_hi); end
        vectors++; if (busy_rise != 1 || busy_cnt != busy_len(2)) begin miscompares++; $display("FAIL ferr_no_retrigger: got rise=%0d cycles=%0d expected 1/%0d", busy_rise, busy_cnt, busy_len(2)); end
        idle(period_of(2));
        send_frame(8'h42, 1'b1, 2, -1);
        idle(20);
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL ferr_recover_count: got %0d expected 1", got_q.size()); end
        else begin
            vectors++; if (got_q[0] !== 8'h42) begin miscompares++; $display("FAIL ferr_recover_data: got %h expected 42", got_q[0]); end
        end
    endtask

    task automatic test_glitch();
        tready = 1'b1;
        prescale = 16'd2;
        clear_mon();
        rxd = 1'b0;
        repeat (3) tick();
        idle(40);
        vectors++; if (busy_rise != 1 || busy_cnt != period_of(2) / 2) begin miscompares++; $display("FAIL glitch_busy: got rise=%0d cycles=%0d expected 1/%0d", busy_rise, busy_cnt, period_of(2) / 2); end
        vectors++; if (tvalid_hi != 0 || ovr_cnt != 0 || fe_cnt != 0) begin miscompares++; $display("FAIL glitch_outputs: got tv=%0d ovr=%0d fe=%0d expected 0/0/0", tvalid_hi, ovr_cnt, fe_cnt); end
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] d;
        d = 8'h81;
        tready = 1'b1;
        prescale = 16'd1;
        clear_mon();
        rxd = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            repeat (8) tick();
        end
        rxd = d[4];
        repeat (4) tick();
        rst_n = 1'b0;
        rxd = 1'b1;
        tick();
        vectors++; if (busy !== 1'b0 || tvalid !== 1'b0 || tdata !== '0 || ovr !== 1'b0 || fe !== 1'b0) begin
            miscompares++; $display("FAIL midreset_outputs: got busy=%b tv=%b td=%h ovr=%b fe=%b expected all 0", busy, tvalid, tdata, ovr, fe);
        end
        tick();
        rst_n = 1'b1;
        idle(10);
        send_frame(8'h18, 1'b1, 1, -1);
        idle(20);
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL midreset_count: got %0d expected 1", got_q.size()); end
        else begin
            vectors++; if (got_q[0] !== 8'h18) begin miscompares++; $display("FAIL midreset_data: got %h expected 18", got_q[0]); end
        end
        vectors++; if (fe_cnt != 0 || ovr_cnt != 0) begin miscompares++; $display("FAIL midreset_errors: got fe=%0d ovr=%0d expected 0/0", fe_cnt, ovr_cnt); end
    endtask

    task automatic test_prescale_zero();
        int lat[2];
        int bc[2];
        tready = 1'b1;
        for (int ps = 0; ps < 2; ps++) begin
            int t0;
            clear_mon();
            t0 = cyc;
            send_frame(8'h5A, 1'b1, ps, -1);
            idle(20);
            lat[ps] = tvalid_rise_cyc - t0;
            bc[ps]  = busy_cnt;
            vectors++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin miscompares++; $display("FAIL ps%0d_data: got %0d words expected one 5a", ps, got_q.size()); end
        end
        vectors++; if (lat[0] != lat[1]) begin miscompares++; $display("FAIL ps0_latency: got %0d expected %0d", lat[0], lat[1]); end
        vectors++; if (bc[0] != busy_len(1) || bc[1] != busy_len(1)) begin miscompares++; $display("FAIL ps0_busy: got %0d/%0d expected %0d", bc[0], bc[1], busy_len(1)); end
    endtask

    // Random stream: back-to-back frames, random prescale with mid-frame
    // changes, and occasional bad stop bits. tready stays high.
    task automatic test_random_stream();
        logic [W-1:0] exp_q[$];
        int exp_fe, exp_busy;
        exp_fe = 0;
        exp_busy = 0;
        tready = 1'b1;
        clear_mon();
        for (int n = 0; n < 16; n++) begin
            logic [W-1:0] d;
            int ps, bad;
            d   = W'($urandom);
            ps  = int'($urandom_range(0, 3));
            bad = ($urandom_range(0, 4) == 0) ? 1 : 0;
            send_frame(d, (bad == 0), ps, int'($urandom_range(0, 7)));
            exp_busy += busy_len(ps);
            if (bad != 0) begin
                exp_fe++;
                idle(period_of(ps));
            end else begin
                exp_q.push_back(d);
                if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 20)));
            end
        end
        idle(20);
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL stream_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL stream_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
            end
        end
        vectors++; if (fe_cnt != exp_fe) begin miscompares++; $display("FAIL stream_frame_errors: got %0d expected %0d", fe_cnt, exp_fe); end
        vectors++; if (busy_cnt != exp_busy) begin miscompares++; $display("FAIL stream_busy: got %0d expected %0d", busy_cnt, exp_busy); end
        vectors++; if (ovr_cnt != 0) begin miscompares++; $display("FAIL stream_overrun: got %0d expected 0", ovr_cnt); end
    endtask

    // Random backpressure: words are consumed only when the bench chooses.
    // Each word committed over a pending one is one overrun.
    task automatic test_backpressure();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] last;
        int pending, exp_ovr;
        pending = 0;
        exp_ovr = 0;
        last = '0;
        tready = 1'b0;
        clear_mon();
        for (int n = 0; n < 10; n++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            send_frame(d, 1'b1, int'($urandom_range(0, 2)), -1);
            idle(5);
            if (pending != 0) exp_ovr++;
            pending = 1;
            last = d;
            vectors++; if (tvalid !== 1'b1 || tdata !== d) begin miscompares++; $display("FAIL bp_word%0d: got %b/%h expected 1/%h", n, tvalid, tdata, d); end
            if ($urandom_range(0, 1) == 1) begin
                drain();
                exp_q.push_back(last);
                pending = 0;
            end
        end
        vectors++; if (ovr_cnt != exp_ovr) begin miscompares++; $display("FAIL bp_overruns: got %0d expected %0d", ovr_cnt, exp_ovr); end
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_drained%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
            end
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        rxd = 1'b1;
        tready = 1'b0;
        prescale = 16'd1;
        clear_mon();
        test_reset();
        test_basic();
        test_overrun();
        test_commit_handshake();
        test_frame_error();
        test_glitch();
        test_reset_midframe();
        test_prescale_zero();
        test_random_stream();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per UART frame (5..9 supported).
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port m_axis_tdata, output, DATA_WIDTH, received data word.
REQ-005 SHALL have port m_axis_tvalid, output, 1, m_axis_tdata holds an unconsumed word.
REQ-006 SHALL have port m_axis_tready, input, 1, downstream accepts the word.
REQ-007 SHALL have port rxd, input, 1, asynchronous UART serial line, idle high.
REQ-008 SHALL have port busy, output, 1, a frame is being received.
REQ-009 SHALL have port overrun_error, output, 1, one-cycle pulse when an unconsumed word is overwritten.
REQ-010 SHALL have port frame_error, output, 1, one-cycle pulse when a stop bit samples low.
REQ-011 SHALL have port prescale, input, 16, bit period = prescale*8 clk cycles (value 0 treated as 1).

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer reset to 1; all decisions use the synchronized value (rxs).
REQ-013 SHALL frame: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1); no parity.
REQ-014 SHALL capture prescale into a 19-bit period register P = prescale*8 on start detection and hold it for the whole frame.
REQ-015 SHALL implement states IDLE, START, DATA, STOP with a 19-bit down-counter and a bit counter.
REQ-016 IDLE: on rxs==0 SHALL load counter with P/2-1, assert busy, go START.
REQ-017 START: at counter==0 SHALL re-sample rxs; if 0 load counter P-1, go DATA; if 1 (glitch) deassert busy, return IDLE, no error pulse.
REQ-018 DATA: at each counter==0 SHALL shift rxs into the MSB of a DATA_WIDTH shift register (right shift), reload P-1; after DATA_WIDTH samples go STOP.
REQ-019 STOP: at counter==0 SHALL sample rxs; if 1 commit the shift register to m_axis_tdata and set m_axis_tvalid; if 0 pulse frame_error, discard word, leave m_axis_tdata/m_axis_tvalid unchanged.
REQ-020 After the stop sample SHALL deassert busy and go IDLE the next cycle; IDLE SHALL only accept a start once rxs has been seen 1 (a held-low line after frame_error SHALL NOT retrigger until it returns high).
REQ-021 m_axis_tvalid SHALL clear on a cycle with m_axis_tvalid && m_axis_tready and no commit in that cycle.
REQ-022 Commit while m_axis_tvalid==1 and m_axis_tready==0 SHALL overwrite m_axis_tdata, keep tvalid 1, and pulse overrun_error for one cycle.
REQ-023 Commit in the same cycle as a completing handshake SHALL load the new word, keep tvalid 1, no overrun_error.
REQ-024 m_axis_tdata SHALL be stable while m_axis_tvalid==1 except on a commit (REQ-022/023).
REQ-025 Changes to prescale mid-frame SHALL have no effect until the next start detection.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, counters 0, synchronizer 1, m_axis_tdata 0, m_axis_tvalid 0, busy 0, overrun_error 0, frame_error 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no commit and no error pulse; after release the block waits for rxs high before detecting a start.

Verification
REQ-028 prescale=1 (8-cycle bit), rxd sends 0x55, tready=1 -> tvalid one cycle with tdata=0x55, busy high for ~76 cycles, no error pulses.
REQ-029 prescale=4, send 0xA3 then 0x3C with tready=0 -> 0xA3 held, second commit shows tdata=0x3C, overrun_error one-cycle pulse, tvalid stays 1.
REQ-030 prescale=2, send 0xFF with stop bit forced 0 -> frame_error one-cycle pulse, tvalid stays 0, no new start until rxd returns high.
REQ-031 prescale=2, rxd low pulse of 3 cycles then high -> busy pulses then clears at START check, no tvalid, no errors.
REQ-032 prescale=1, drop rst_n during data bit 4 of 0x81, release, send 0x18 -> only 0x18 delivered, all outputs 0 during reset.
REQ-033 prescale=0 vs prescale=1, same frame 0x5A -> identical timing and tdata=0x5A.
